// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// Runs a 32-step shift-add multiply or restoring divide on magnitudes,
// then applies sign correction. Divide-by-zero and signed overflow take a
// short special path.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             operation request (held while the M op sits in EX)
//   funct3            RV32M operation select
//   rs1, rs2          operands A and B
//   flush             synchronous abort from a pipeline redirect
//   busy              high whenever the sequencer is not idle
//   done              one-cycle pulse, result valid in the same cycle
//   result            registered result, held until the next completion
//   stall             combinational EX-stage hold request
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int unsigned CW  = $clog2(XLEN) + 1;
  localparam int unsigned AW  = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    SPEC = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Operand decode in IDLE: signedness, magnitudes and special cases.
  logic            sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_val;

  assign sgn_a_in = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign sgn_b_in = sgn_a_in && (funct3 != 3'b010);
  assign neg_a_in = sgn_a_in && rs1[XLEN-1];
  assign neg_b_in = sgn_b_in && rs2[XLEN-1];
  assign mag_a_in = neg_a_in ? (XLEN'(0) - rs1) : rs1;
  assign mag_b_in = neg_b_in ? (XLEN'(0) - rs2) : rs2;
  assign div_zero = funct3[2] && (rs2 == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    spec_val = '0;
    if (div_zero) spec_val = funct3[1] ? rs1 : '1;
    else          spec_val = funct3[1] ? '0  : MIN_NEG;
  end

  // Multiply step: add multiplicand into the upper half, shift right with carry.
  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum;
  assign mul_add = b_q[0] ? a_q : '0;
  assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, mul_add};

  // Divide step: dividend bits stream in from the top of a_q; remainder
  // needs one spare bit because 2*rem+1 can exceed XLEN bits.
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] rem_new;
  assign rem_sh   = {acc_q[AW-1:XLEN], a_q[XLEN-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};
  assign div_ok   = ~div_diff[XLEN+1];
  assign rem_new  = div_ok ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];

  // Sign correction of the finished magnitudes.
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  assign prod_fix = (neg_a_q ^ neg_b_q) ? (AW'(0) - acc_q) : acc_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_a_q ? (XLEN'(0) - acc_q[AW-1:XLEN]) : acc_q[AW-1:XLEN];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d    = funct3;
            neg_a_d = neg_a_in;
            neg_b_d = neg_b_in;
            a_d     = mag_a_in;
            b_d     = mag_b_in;
            cnt_d   = '0;
            if (div_zero || div_ovf) begin
              acc_d   = {{XLEN{1'b0}}, spec_val};
              state_d = SPEC;
            end else begin
              acc_d   = '0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d = {rem_new, acc_q[XLEN-2:0], div_ok};
            a_d   = a_q << 1;
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        end
        FIX: begin
          case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[AW-1:XLEN];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
          endcase
          state_d = DONE;
        end
        SPEC: begin
          result_d = acc_q[XLEN-1:0];
          state_d  = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = ((state_q == IDLE) && start) ||
                  (state_q == CALC) || (state_q == FIX) || (state_q == SPEC);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of reference-model results,
// latency and stall checks, flush, reset and back-to-back scenarios.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference built from 64-bit native arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] ua, ubu, p;
    logic signed [31:0] a32, b32;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'h0, b};
    ua  = {32'h0, a};
    ubu = {32'h0, b};
    a32 = a;
    b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub;   return p[63:32]; end
      3'd3: begin p = ua * ubu;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(a32 / b32);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(a32 % b32);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Drives one operation from IDLE and waits for done (cycle 0 = start cycle).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit tout, output bit stall_bad);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    exp_q.push_back(model(f, a, b));
    res = 'x; lat = -1; tout = 1'b1; stall_bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (c == 1) begin rs1 = ~a; rs2 = $urandom; funct3 = 3'($urandom_range(7)); end
      if (done) begin
        res = result; lat = c; tout = 1'b0;
        if (stall !== 1'b0) stall_bad = 1'b1;
        break;
      end
      if (stall !== 1'b1) stall_bad = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, stall, result} !== 35'h0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b stall=%b result=%h want all zero", busy, done, stall, result);
    end
    rst_n = 1'b1;
  endtask

  // Runs a list of ops and compares result and latency against the scoreboard.
  task automatic test_ops(input string name, input logic [2:0] f[], input logic [31:0] a[], input logic [31:0] b[]);
    logic [31:0] res, exp;
    int lat;
    bit tout, sbad;
    for (int i = 0; i < f.size(); i++) begin
      run_op(f[i], a[i], b[i], res, lat, tout, sbad);
      exp = exp_q.pop_front();
      checks++;
      if (tout) begin
        failures++;
        $display("FAIL %s[%0d] timeout no done f=%0d a=%h b=%h", name, i, f[i], a[i], b[i]);
        continue;
      end
      if (res !== exp) begin
        failures++;
        $display("FAIL %s[%0d] result f=%0d a=%h b=%h got %h want %h", name, i, f[i], a[i], b[i], res, exp);
      end
      checks++;
      if (lat != exp_lat(f[i], a[i], b[i])) begin
        failures++;
        $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, exp_lat(f[i], a[i], b[i]));
      end
      checks++;
      if (sbad) begin
        failures++;
        $display("FAIL %s[%0d] stall profile wrong", name, i);
      end
      last_res = exp;
    end
  endtask

  task automatic test_mul;
    test_ops("mul_7x-3", '{3'd0}, '{32'd7}, '{32'hFFFF_FFFD});
    checks++;
    if (last_res !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL mul_const got %h want ffffffeb", last_res);
    end
    test_ops("mulh_var", '{3'd1, 3'd3, 3'd2},
             '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
             '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
  endtask

  task automatic test_div;
    test_ops("div_basic", '{3'd4, 3'd6, 3'd5, 3'd7},
             '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
             '{32'd2, 32'd2, 32'd7, 32'd7});
  endtask

  task automatic test_special;
    test_ops("div_spec", '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6},
             '{32'd5, 32'd5, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000},
             '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
  endtask

  task automatic test_flush;
    int pulses;
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd1234; rs2 = 32'd5678; start = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
      failures++;
      $display("FAIL flush_calc got busy=%b done=%b result=%h want 0 0 %h", busy, done, result, last_res);
    end
    pulses = 0;
    repeat (40) begin @(negedge clk); #1; if (done) pulses++; end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL flush_nodone got %0d done pulses want 0", pulses);
    end
    // flush together with start in IDLE must not accept the op
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd10; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_idle got busy=%b want 0", busy);
    end
    test_ops("after_flush", '{3'd0}, '{32'd1234}, '{32'd5678});
  endtask

  task automatic test_reset_mid_calc;
    @(negedge clk);
    funct3 = 3'd1; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; start = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({busy, stall, done, result} !== 35'h0) begin
      failures++;
      $display("FAIL reset_mid_calc got busy=%b stall=%b done=%b result=%h want all zero", busy, stall, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    test_ops("after_reset", '{3'd3}, '{32'hDEAD_BEEF}, '{32'h0000_1001});
  endtask

  // start held across DONE is only re-accepted once the sequencer is IDLE.
  task automatic test_back_to_back;
    logic [31:0] exp;
    bit seen;
    @(negedge clk);
    funct3 = 3'd4; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1;
    exp_q.push_back(model(3'd4, 32'd5, 32'd0));
    repeat (2) @(negedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || result !== exp) begin
      failures++;
      $display("FAIL hold_done1 got done=%b result=%h want 1 %h", done, result, exp);
    end
    exp_q.push_back(model(3'd4, 32'd5, 32'd0));
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle got busy=%b stall=%b done=%b want 0 1 0", busy, stall, done);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_restart got busy=%b want 1", busy);
    end
    seen = 1'b0;
    @(negedge clk); #1;
    if (done) seen = 1'b1;
    start = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (!seen || result !== exp) begin
      failures++;
      $display("FAIL hold_done2 got done=%b result=%h want 1 %h", seen, result, exp);
    end
    last_res = exp;
    test_ops("b2b", '{3'd0, 3'd7, 3'd6, 3'd2}, '{32'hFFFF_0001, 32'd77, 32'h8000_0001, 32'h8000_0000},
             '{32'h0001_0003, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
  endtask

  task automatic test_random;
    logic [2:0]  f[];
    logic [31:0] a[];
    logic [31:0] b[];
    f = new[24]; a = new[24]; b = new[24];
    for (int i = 0; i < 24; i++) begin
      f[i] = 3'(i % 8);
      a[i] = $urandom;
      b[i] = (i % 7 == 3) ? 32'd0 : ((i % 5 == 1) ? 32'($urandom_range(15)) : $urandom);
    end
    test_ops("random", f, a, b);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
